// File: rtl/mp_ram_lat.sv
// N-port synchronous RAM with per-port read pipelines of configurable latency.
// Same-address write collisions resolve to the lowest-numbered port and are counted.
module mp_ram_lat #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*NUM_PORTS-1:0]      op,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [DATA_W*NUM_PORTS-1:0] wdata,
    output logic [DATA_W*NUM_PORTS-1:0] rdata,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic                        wr_coll,
    output logic [7:0]                  coll_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_NONE  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    op_e               port_op    [NUM_PORTS];
    logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
    logic [DATA_W-1:0] port_wdata [NUM_PORTS];

    logic [NUM_PORTS-1:0] wr_en;
    logic                 coll_now;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] pipe_data  [NUM_PORTS][RD_LAT];
    logic [RD_LAT-1:0] pipe_valid [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_op[p]    = op_e'(op[2*p +: 2]);
            port_addr[p]  = addr[ADDR_W*p +: ADDR_W];
            port_wdata[p] = wdata[DATA_W*p +: DATA_W];
        end
    end

    // A write survives only if no lower-numbered port writes the same address this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wr_en    = '0;
        coll_now = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_op[p] == OP_WRITE) begin
                wr_en[p] = 1'b1;
                for (int q = 0; q < p; q++) begin
                    if (port_op[q] == OP_WRITE && port_addr[q] == port_addr[p]) begin
                        wr_en[p] = 1'b0;
                        coll_now = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array must read back zero after reset, so it is cleared here and maps to flops, not an SRAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_en[p]) begin
                    mem[port_addr[p]] <= port_wdata[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pipe_valid[p] <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    pipe_data[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                // NOTE: mem is updated with non-blocking assignments, so this read sees the pre-write value (read-first).
                pipe_valid[p][0] <= (port_op[p] == OP_READ);
                if (port_op[p] == OP_READ) begin
                    pipe_data[p][0] <= mem[port_addr[p]];
                end
                // Data only advances with a valid read, so the last stage holds its value between reads.
                for (int k = 1; k < RD_LAT; k++) begin
                    pipe_valid[p][k] <= pipe_valid[p][k-1];
                    if (pipe_valid[p][k-1]) begin
                        pipe_data[p][k] <= pipe_data[p][k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata  = '0;
        rvalid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata[DATA_W*p +: DATA_W] = pipe_data[p][RD_LAT-1];
            rvalid[p]                 = pipe_valid[p][RD_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_coll  <= 1'b0;
            coll_cnt <= 8'd0;
        end else begin
            wr_coll <= coll_now;
            if (coll_now && coll_cnt != 8'hFF) begin
                coll_cnt <= coll_cnt + 8'd1;
            end
        end
    end

endmodule
